// File: rtl/mrs_pkg.sv
// Shared definitions for the bit-serial masking rotating shifter:
// mode encodings and the sequencing FSM states.
package mrs_pkg;

    localparam logic [1:0] MRS_ROR = 2'b00;
    localparam logic [1:0] MRS_ROL = 2'b01;
    localparam logic [1:0] MRS_SRL = 2'b10;
    localparam logic [1:0] MRS_SLL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } mrs_state_e;

endpackage

// File: rtl/mrs_step.sv
// Single-position step of the rotating shifter. Rotates wrap the end bit around;
// logical shifts fill the vacated position with zero.
module mrs_step
    import mrs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q
);

    // One-bit move selected by mode
    always_comb begin
        q = d;
        case (mode)
            MRS_ROR: q = {d[0], d[WIDTH-1:1]};
            MRS_ROL: q = {d[WIDTH-2:0], d[WIDTH-1]};
            MRS_SRL: q = {1'b0, d[WIDTH-1:1]};
            MRS_SLL: q = {d[WIDTH-2:0], 1'b0};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/mrs_8_serial.sv
// Bit-serial masking rotating shifter: accepts one request, steps the data one
// position per clock for amt cycles, then holds the result until drained.
module mrs_8_serial
    import mrs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    mrs_state_e       r_state;
    mrs_state_e       w_state_next;
    logic [AMT_W-1:0] r_cnt;
    logic [AMT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_next;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_next;
    logic [WIDTH-1:0] w_step;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_accept;

    mrs_step #(.WIDTH(WIDTH)) u_step (
        .d    (r_data),
        .mode (r_mode),
        .q    (w_step)
    );

    // in_ready is a register so it stays low for the whole reset pulse
    assign w_accept  = in_valid && r_in_ready && (r_state == IDLE);
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_data;
    assign busy      = r_busy;

    // Next-state, counter and datapath selection
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_data_next  = r_data;
        w_mode_next  = r_mode;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_data_next = in_data;
                    w_mode_next = in_mode;
                    w_cnt_next  = in_amt;
                    if (in_amt == {AMT_W{1'b0}}) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = SHIFT;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            SHIFT: begin
                w_data_next = w_step;
                w_cnt_next  = r_cnt - AMT_W'(1);
                if (r_cnt == AMT_W'(1)) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= {AMT_W{1'b0}};
            r_data      <= {WIDTH{1'b0}};
            r_mode      <= MRS_ROR;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_data      <= w_data_next;
            r_mode      <= w_mode_next;
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
            r_busy      <= (w_state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_mrs_8_serial.sv
// Directed bench for mrs_8_serial: hand-computed vectors, backpressure, reset
// abort, plus a randomised run against an operator-based reference shifter.
module tb_mrs_8_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_amt = 3'd0;
    logic [1:0] in_mode = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    mrs_8_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input logic [1:0] m);
        logic [15:0] t;
        t = {d, d};
        case (m)
            2'b00: begin t = t >> a; return t[7:0]; end
            2'b01: begin t = t << a; return t[15:8]; end
            2'b10: return d >> a;
            default: return d << a;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic accept(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); @(negedge clk); w++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'(~d); in_amt = 3'(a + 3'd1); in_mode = 2'(m + 2'd1);
    endtask

    task automatic directed(input string tag, input logic [7:0] d, input logic [2:0] a,
                            input logic [1:0] m, input logic [7:0] exp);
        int edges;
        accept(d, a, m);
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk); @(negedge clk); edges++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_latency"}, edges, 32'(a) + 32'd1);
        chk({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
        chk({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drained"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int edges;
        int got;
        int cyc;
        int a;
        int m;
        logic [7:0] d;
        logic [7:0] res;

        #1;
        chk("rst_outputs", {20'd0, in_ready, out_valid, busy, 1'b0, out_data}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("rst_in_ready_held", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_pre_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("rst_release_ready", {30'd0, in_ready, busy}, 32'd2);

        directed("ror3", 8'h96, 3'd3, 2'b00, 8'hD2);
        directed("rol3", 8'h96, 3'd3, 2'b01, 8'hB4);
        directed("srl3", 8'h96, 3'd3, 2'b10, 8'h12);
        directed("sll3", 8'h96, 3'd3, 2'b11, 8'hB0);
        directed("ror0", 8'h96, 3'd0, 2'b00, 8'h96);
        directed("rol0", 8'h96, 3'd0, 2'b01, 8'h96);
        directed("srl0", 8'h96, 3'd0, 2'b10, 8'h96);
        directed("sll0", 8'h96, 3'd0, 2'b11, 8'h96);
        directed("rol7", 8'h96, 3'd7, 2'b01, 8'h4B);
        directed("ror7", 8'h96, 3'd7, 2'b00, 8'h2D);
        directed("srl7", 8'h96, 3'd7, 2'b10, 8'h01);
        directed("sll7", 8'h96, 3'd7, 2'b11, 8'h00);
        directed("ror1", 8'h96, 3'd1, 2'b00, 8'h4B);

        // Backpressure with in_valid held high in DONE
        accept(8'h96, 3'd3, 2'b00);
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk); @(negedge clk); edges++;
        end
        in_valid = 1'b1; in_data = 8'h55; in_amt = 3'd1; in_mode = 2'b11;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {21'd0, out_valid, in_ready, busy, out_data}, {21'd0, 3'b101, 8'hD2});
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_release", {29'd0, out_valid, in_ready, busy}, 32'd2);

        // Reset two cycles into an amt=7 request
        accept(8'h96, 3'd7, 2'b01);
        @(posedge clk); @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_async", {20'd0, in_ready, out_valid, busy, 1'b0, out_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) got++;
        end
        chk("abort_no_result", got, 32'd0);
        directed("post_abort_rol3", 8'h96, 3'd3, 2'b01, 8'hB4);

        // Randomised requests with random backpressure
        for (int n = 0; n < 2000; n++) begin
            d = 8'($urandom);
            a = int'($urandom_range(0, 7));
            m = int'($urandom_range(0, 3));
            accept(d, 3'(a), 2'(m));
            got = 0; cyc = 0; res = 8'h00;
            while (got == 0 && cyc < 64) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    got++;
                    res = out_data;
                end
                @(posedge clk); @(negedge clk);
                cyc++;
            end
            out_ready = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (out_valid) got++;
                @(posedge clk); @(negedge clk);
            end
            chk("rand_one_result", got, 32'd1);
            chk("rand_data", {24'd0, res}, {24'd0, ref_shift(d, a, 2'(m))});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
